// File: rtl/sdram_sched_pkg.sv
// Shared types and default timing constants for the SDRAM bus scheduler.
package sdram_sched_pkg;

  localparam int DEF_REFRESH_CYCLES = 780;
  localparam int DEF_FIN_TIMEOUT    = 255;

  typedef enum logic [3:0] {
    ST_INIT_START = 4'd0,
    ST_INIT_WAIT  = 4'd1,
    ST_IDLE       = 4'd2,
    ST_REF_START  = 4'd3,
    ST_REF_WAIT   = 4'd4,
    ST_WR_START   = 4'd5,
    ST_WR_WAIT    = 4'd6,
    ST_RD_START   = 4'd7,
    ST_RD_WAIT    = 4'd8,
    ST_GAP        = 4'd9
  } sched_state_e;

  typedef enum logic {
    SRV_READ  = 1'b0,
    SRV_WRITE = 1'b1
  } served_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh demand: down-counter that raises pending on expiry and
// flags an overrun when the previous demand has not been picked up yet.
module sdram_refresh_timer
  import sdram_sched_pkg::*;
#(
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic iclk,
  input  logic ctr_reset,
  input  logic en_i,
  input  logic clr_pending_i,
  output logic pending_o,
  output logic overrun_o
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          expire_s;

  // Next-state for counter and flags; a fresh expiry wins over a same-cycle clear.
  always_comb begin
    expire_s = en_i && (cnt_q == '0);
    if (!en_i)        cnt_d = cnt_q;
    else if (expire_s) cnt_d = RELOAD;
    else              cnt_d = cnt_q - CW'(1);
    pending_d = expire_s | (pending_q & ~clr_pending_i);
    overrun_d = overrun_q | (expire_s & pending_q & ~clr_pending_i);
  end

  // Timer registers.
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sdram_scheduler.sv
// SDRAM bus sequencer: init once, then grants the bus to one of the refresh,
// write or read engines at a time with fin timeouts and a turnaround gap.
module sdram_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int FIN_TIMEOUT    = DEF_FIN_TIMEOUT
) (
  input  logic iclk,
  input  logic ctr_reset,
  input  logic iwr_req,
  input  logic ird_req,
  output logic owr_ack,
  output logic ord_ack,
  output logic oinit_done,
  output logic obusy,
  output logic oref_overrun,
  output logic otimeout,
  output logic init_req,
  output logic ref_req,
  output logic wr_req,
  output logic rd_req,
  output logic init_enb,
  output logic ref_enb,
  output logic wr_enb,
  output logic rd_enb,
  input  logic init_fin,
  input  logic ref_fin,
  input  logic wr_fin,
  input  logic rd_fin
);

  localparam logic [7:0] TO_LAST = 8'(FIN_TIMEOUT - 1);

  sched_state_e state_q, state_d;
  served_e      last_q, last_d;
  logic [7:0]   to_cnt_q, to_cnt_d;
  logic         fin_s, to_hit_s, clr_pend_s, ref_pend_s;
  logic         init_ok_s, wr_ok_s, rd_ok_s;

  sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_ref_timer (
    .iclk          (iclk),
    .ctr_reset     (ctr_reset),
    .en_i          (oinit_done),
    .clr_pending_i (clr_pend_s),
    .pending_o     (ref_pend_s),
    .overrun_o     (oref_overrun)
  );

  // Completion from whichever engine currently owns the bus.
  always_comb begin
    case (state_q)
      ST_INIT_WAIT: fin_s = init_fin;
      ST_REF_WAIT:  fin_s = ref_fin;
      ST_WR_WAIT:   fin_s = wr_fin;
      ST_RD_WAIT:   fin_s = rd_fin;
      default:      fin_s = 1'b0;
    endcase
  end

  // Next state, arbitration and timeout counter.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    to_cnt_d   = to_cnt_q;
    to_hit_s   = 1'b0;
    clr_pend_s = 1'b0;
    case (state_q)
      ST_INIT_START: begin
        to_cnt_d = 8'd0;
        // Out of reset the start pulse has not been shown yet; hold one cycle for it.
        if (init_req) state_d = ST_INIT_WAIT;
        else          state_d = ST_INIT_START;
      end
      ST_REF_START: begin to_cnt_d = 8'd0; state_d = ST_REF_WAIT; end
      ST_WR_START:  begin to_cnt_d = 8'd0; state_d = ST_WR_WAIT;  end
      ST_RD_START:  begin to_cnt_d = 8'd0; state_d = ST_RD_WAIT;  end
      ST_INIT_WAIT, ST_REF_WAIT, ST_WR_WAIT, ST_RD_WAIT: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (fin_s) begin
          state_d = ST_GAP;
        end else if (to_cnt_q == TO_LAST) begin
          to_hit_s = 1'b1;
          state_d  = (state_q == ST_INIT_WAIT) ? ST_INIT_START : ST_GAP;
        end else begin
          state_d = state_q;
        end
      end
      ST_IDLE: begin
        if (ref_pend_s) begin
          state_d    = ST_REF_START;
          clr_pend_s = 1'b1;
        end else if (iwr_req && (!ird_req || last_q == SRV_READ)) begin
          state_d = ST_WR_START;
          last_d  = SRV_WRITE;
        end else if (ird_req) begin
          state_d = ST_RD_START;
          last_d  = SRV_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_INIT_START;
    endcase
  end

  assign init_ok_s = (state_q == ST_INIT_WAIT) && fin_s;
  assign wr_ok_s   = (state_q == ST_WR_WAIT) && fin_s;
  assign rd_ok_s   = (state_q == ST_RD_WAIT) && fin_s;

  // State register plus outputs registered from the state being entered.
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state_q    <= ST_INIT_START;
      last_q     <= SRV_READ;
      to_cnt_q   <= 8'd0;
      init_req   <= 1'b0;
      ref_req    <= 1'b0;
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      init_enb   <= 1'b0;
      ref_enb    <= 1'b0;
      wr_enb     <= 1'b0;
      rd_enb     <= 1'b0;
      obusy      <= 1'b0;
      owr_ack    <= 1'b0;
      ord_ack    <= 1'b0;
      oinit_done <= 1'b0;
      otimeout   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      to_cnt_q   <= to_cnt_d;
      init_req   <= (state_d == ST_INIT_START);
      ref_req    <= (state_d == ST_REF_START);
      wr_req     <= (state_d == ST_WR_START);
      rd_req     <= (state_d == ST_RD_START);
      init_enb   <= (state_d == ST_INIT_START) || (state_d == ST_INIT_WAIT);
      ref_enb    <= (state_d == ST_REF_START) || (state_d == ST_REF_WAIT);
      wr_enb     <= (state_d == ST_WR_START) || (state_d == ST_WR_WAIT);
      rd_enb     <= (state_d == ST_RD_START) || (state_d == ST_RD_WAIT);
      obusy      <= (state_d != ST_IDLE);
      owr_ack    <= wr_ok_s;
      ord_ack    <= rd_ok_s;
      oinit_done <= oinit_done | init_ok_s;
      otimeout   <= otimeout | to_hit_s;
    end
  end

endmodule

// File: tb/tb_sdram_scheduler.sv
// Randomised bench for sdram_scheduler against a transaction-age model of the bus.
module tb_sdram_scheduler;

  localparam int RC = 20;
  localparam int FT = 255;

  logic iclk = 1'b0;
  logic ctr_reset = 1'b1;
  logic iwr_req = 1'b0, ird_req = 1'b0;
  logic init_fin = 1'b0, ref_fin = 1'b0, wr_fin = 1'b0, rd_fin = 1'b0;
  logic owr_ack, ord_ack, oinit_done, obusy, oref_overrun, otimeout;
  logic init_req, ref_req, wr_req, rd_req, init_enb, ref_enb, wr_enb, rd_enb;

  sdram_scheduler #(.REFRESH_CYCLES(RC), .FIN_TIMEOUT(FT)) dut (
    .iclk(iclk), .ctr_reset(ctr_reset), .iwr_req(iwr_req), .ird_req(ird_req),
    .owr_ack(owr_ack), .ord_ack(ord_ack), .oinit_done(oinit_done), .obusy(obusy),
    .oref_overrun(oref_overrun), .otimeout(otimeout),
    .init_req(init_req), .ref_req(ref_req), .wr_req(wr_req), .rd_req(rd_req),
    .init_enb(init_enb), .ref_enb(ref_enb), .wr_enb(wr_enb), .rd_enb(rd_enb),
    .init_fin(init_fin), .ref_fin(ref_fin), .wr_fin(wr_fin), .rd_fin(rd_fin)
  );

  always #5 iclk = ~iclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: owner kind (0 init, 1 ref, 2 wr, 3 rd, -1 idle) and cycles since its start.
  int m_kind, m_age, m_ack, m_rcnt;
  bit m_gap, m_done, m_to, m_ovr, m_pend, m_last_wr;

  bit rst_hold = 1'b1;
  bit c_wr = 1'b0, c_rd = 1'b0;
  int want_wr = 0, want_rd = 0;
  int fin_delay[4] = '{10, 0, 0, 0};
  int fin_at[4]    = '{-1, -1, -1, -1};

  int run_len[4]  = '{0, 0, 0, 0};
  int last_run[4] = '{0, 0, 0, 0};
  bit run_done[4];
  int done_at_init_end = 0;
  int ack_cnt_wr = 0;
  int grants[$];

  task automatic model_reset();
    m_kind = 0; m_age = -1; m_ack = -1; m_gap = 1'b0;
    m_done = 1'b0; m_to = 1'b0; m_ovr = 1'b0; m_pend = 1'b0;
    m_last_wr = 1'b0; m_rcnt = RC - 1;
  endtask

  function automatic logic [3:0] m_reqs();
    logic [3:0] r = 4'b0000;
    if (m_kind >= 0 && m_age == 0 && !m_gap) r[m_kind] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] m_enbs();
    logic [3:0] e = 4'b0000;
    if (m_kind >= 0 && m_age >= 0 && !m_gap) e[m_kind] = 1'b1;
    return e;
  endfunction

  function automatic logic [13:0] exp_vec();
    return {m_reqs(), m_enbs(), (m_gap && m_ack == 2), (m_gap && m_ack == 3),
            m_done, (m_kind >= 0 && m_age >= 0), m_ovr, m_to};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {rd_req, wr_req, ref_req, init_req, rd_enb, wr_enb, ref_enb, init_enb,
            owr_ack, ord_ack, oinit_done, obusy, oref_overrun, otimeout};
  endfunction

  task automatic expect_int(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_cycle();
    logic [13:0] e, a;
    logic [3:0]  den;
    e = exp_vec();
    a = dut_vec();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL outputs cycle %0d: got %b, required %b", cyc, a, e);
    end
    den = a[9:6];
    for (int k = 0; k < 4; k++) begin
      if (den[k]) run_len[k]++;
      else if (run_len[k] > 0) begin
        last_run[k] = run_len[k];
        run_done[k] = 1'b1;
        run_len[k]  = 0;
        if (k == 0) done_at_init_end = int'(oinit_done);
      end
    end
    if (wr_req) grants.push_back(2);
    if (rd_req) grants.push_back(3);
    if (owr_ack) ack_cnt_wr++;
  endtask

  function automatic int pick_delay(int k);
    if (fin_delay[k] > 0) return fin_delay[k];
    if ($urandom_range(0, 39) == 0) return 300;
    return int'($urandom_range(1, 12));
  endfunction

  task automatic drive_inputs();
    logic [3:0] rq, en;
    rq = m_reqs();
    en = m_enbs();
    for (int k = 0; k < 4; k++) begin
      if (!en[k] || rst_hold) fin_at[k] = -1;
      if (rq[k] && !rst_hold) fin_at[k] = cyc + pick_delay(k);
    end
    init_fin = (fin_at[0] == cyc);
    ref_fin  = (fin_at[1] == cyc);
    wr_fin   = (fin_at[2] == cyc);
    rd_fin   = (fin_at[3] == cyc);
    if (m_gap && m_ack == 2) c_wr = (want_wr == 1);
    else if (!c_wr && (want_wr == 1 || (want_wr == 2 && $urandom_range(0, 3) == 0))) c_wr = 1'b1;
    if (m_gap && m_ack == 3) c_rd = (want_rd == 1);
    else if (!c_rd && (want_rd == 1 || (want_rd == 2 && $urandom_range(0, 3) == 0))) c_rd = 1'b1;
    iwr_req   = c_wr;
    ird_req   = c_rd;
    ctr_reset = rst_hold;
  endtask

  // Advance the model across the coming rising edge using the inputs just driven.
  task automatic model_advance();
    logic [3:0] f;
    bit clr, old_pend, old_done;
    if (ctr_reset) return;
    f = {rd_fin, wr_fin, ref_fin, init_fin};
    old_pend = m_pend;
    old_done = m_done;
    clr = 1'b0;
    if (m_kind < 0) begin
      if (old_pend) begin m_kind = 1; m_age = 0; clr = 1'b1; end
      else if (iwr_req && (!ird_req || !m_last_wr)) begin m_kind = 2; m_age = 0; m_last_wr = 1'b1; end
      else if (ird_req) begin m_kind = 3; m_age = 0; m_last_wr = 1'b0; end
    end else if (m_gap) begin
      m_gap = 1'b0; m_kind = -1; m_ack = -1;
    end else if (m_age <= 0) begin
      m_age++;
    end else if (f[m_kind]) begin
      m_gap = 1'b1; m_ack = m_kind;
      if (m_kind == 0) m_done = 1'b1;
    end else if (m_age == FT) begin
      m_to = 1'b1;
      if (m_kind == 0) m_age = 0;
      else begin m_gap = 1'b1; m_ack = -1; end
    end else begin
      m_age++;
    end
    if (old_done && m_rcnt == 0) begin
      m_rcnt = RC - 1;
      if (old_pend && !clr) m_ovr = 1'b1;
      m_pend = 1'b1;
    end else begin
      if (old_done) m_rcnt--;
      if (clr) m_pend = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge iclk);
    check_cycle();
    drive_inputs();
    model_advance();
    cyc++;
  endtask

  task automatic wait_run(int k, int limit, string name);
    int i = 0;
    run_done[k] = 1'b0;
    while (!run_done[k] && i < limit) begin step(); i++; end
    if (!run_done[k]) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no completed enb run within %0d cycles", name, limit);
    end
  endtask

  task automatic drain(int limit);
    int i = 0;
    want_wr = 0; want_rd = 0;
    while ((c_wr || c_rd || m_kind >= 0) && i < limit) begin step(); i++; end
    if (c_wr || c_rd || m_kind >= 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: client still pending after %0d cycles", limit);
    end
  endtask

  initial begin
    int exp_order[4] = '{3, 2, 3, 2};
    int i;
    model_reset();
    repeat (3) step();

    // Init after reset: fin ten cycles after init_req.
    rst_hold = 1'b0;
    wait_run(0, 60, "init run");
    expect_int("init_enb cycles", last_run[0], 11);
    expect_int("init_done in gap", done_at_init_end, 1);

    // Single write with fin six cycles after wr_req.
    fin_delay[2] = 6; ack_cnt_wr = 0; c_wr = 1'b1;
    wait_run(2, 100, "single write");
    expect_int("wr_enb cycles", last_run[2], 7);
    expect_int("owr_ack pulses", ack_cnt_wr, 1);

    // Contention: last grant was a write, so the order alternates starting with read.
    fin_delay[2] = 0; fin_delay[3] = 0;
    grants.delete();
    want_wr = 1; want_rd = 1; c_wr = 1'b1; c_rd = 1'b1;
    i = 0;
    while (grants.size() < 4 && i < 400) begin step(); i++; end
    expect_int("grant count", grants.size() >= 4 ? 4 : grants.size(), 4);
    for (int g = 0; g < 4; g++) expect_int("grant order", (g < grants.size()) ? grants[g] : -1, exp_order[g]);
    drain(1000);

    // Write whose engine never finishes: timeout, overrun, no ack, then retry.
    fin_delay[2] = 2000; ack_cnt_wr = 0; c_wr = 1'b1;
    wait_run(2, 700, "timeout write");
    expect_int("timed-out wr_enb cycles", last_run[2], 256);
    expect_int("otimeout set", int'(otimeout), 1);
    expect_int("oref_overrun set", int'(oref_overrun), 1);
    expect_int("no ack on timeout", ack_cnt_wr, 0);
    fin_delay[2] = 4;
    wait_run(2, 300, "write retry");
    expect_int("retry wr_enb cycles", last_run[2], 5);
    expect_int("retry owr_ack pulses", ack_cnt_wr, 1);
    fin_delay[2] = 0;

    // Random client traffic and engine latencies.
    want_wr = 2; want_rd = 2;
    repeat (3000) step();
    drain(1000);

    // Asynchronous reset while a read is in its wait phase.
    fin_delay[3] = 60; c_rd = 1'b1;
    i = 0;
    while (!(m_kind == 3 && m_age >= 3 && !m_gap) && i < 400) begin step(); i++; end
    expect_int("reached RD_WAIT", int'(rd_enb), 1);
    #1;
    ctr_reset = 1'b1; rst_hold = 1'b1;
    #1;
    expect_int("rd_enb after async reset", int'(rd_enb), 0);
    expect_int("obusy after async reset", int'(obusy), 0);
    expect_int("otimeout cleared", int'(otimeout), 0);
    expect_int("oref_overrun cleared", int'(oref_overrun), 0);
    expect_int("oinit_done cleared", int'(oinit_done), 0);
    model_reset();
    c_rd = 1'b0; c_wr = 1'b0; fin_delay[3] = 0; fin_delay[0] = 3;
    repeat (3) step();
    rst_hold = 1'b0;
    wait_run(0, 60, "re-init run");
    expect_int("re-init enb cycles", last_run[0], 4);
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_scheduler.md
Name: sdram_scheduler

Overview:
- Top-level sequencer for the shared SDRAM command/data bus.
- Runs the init engine once after reset. Then grants the bus to exactly one engine at a time (refresh, write, read) using req/enb/fin handshakes.
- Generates the periodic refresh demand, arbitrates client read/write requests with alternating fairness, and guards each transaction with a timeout.
- Sits between the memory-client logic and the init/refresh/read/write engines. Those engines tri-state their DRAM pins when their enb is low.

Parameters:
- REFRESH_CYCLES, 780: iclk cycles between refresh demands (7.8 us at 100 MHz).
- FIN_TIMEOUT, 255: max cycles in a *_WAIT state before abort; 8-bit counter.

Ports:
- iclk  in  1  system clock; all logic on posedge.
- ctr_reset  in  1  asynchronous, active-high reset.
- iwr_req  in  1  client write request, level; held until owr_ack.
- ird_req  in  1  client read request, level; held until ord_ack.
- owr_ack  out  1  one-cycle pulse, write transaction finished.
- ord_ack  out  1  one-cycle pulse, read transaction finished.
- oinit_done  out  1  high once initialisation completed; sticky until reset.
- obusy  out  1  high in any state other than IDLE.
- oref_overrun  out  1  sticky: refresh interval expired while previous refresh still pending.
- otimeout  out  1  sticky: some engine failed to assert fin within FIN_TIMEOUT.
- init_req / ref_req / wr_req / rd_req  out  1 each  one-cycle start pulse to the engine.
- init_enb / ref_enb / wr_enb / rd_enb  out  1 each  bus ownership; at most one high in any cycle.
- init_fin / ref_fin / wr_fin / rd_fin  in  1 each  engine completion; high for at least one cycle.

Behaviour:
- Reset: ctr_reset asynchronous, active-high; clock iclk.
  - During reset: state=INIT_START, all outputs 0, refresh counter=REFRESH_CYCLES-1, ref_pending=0, last_served=READ, timeout counter=0.
  - Reset mid-transaction drops every enb immediately; no fin is awaited.
- Outputs are Moore-decoded from the state register; no combinational input-to-output paths.
- States: INIT_START, INIT_WAIT, IDLE, REF_START, REF_WAIT, WR_START, WR_WAIT, RD_START, RD_WAIT, GAP.
- X_START (X = INIT/REF/WR/RD): X_req=1, X_enb=1, clear timeout counter. Next state is X_WAIT.
- X_WAIT: X_enb=1, timeout counter increments.
  - X_fin=1 → GAP.
  - Timeout counter reaches FIN_TIMEOUT → GAP and set otimeout.
  - If both occur in the same cycle, fin wins and otimeout stays 0.
- GAP: all enb=0 for exactly one cycle (bus turnaround), then IDLE.
  - Entered from WR_WAIT via fin: owr_ack=1 in GAP. Same rule for RD_WAIT and ord_ack.
  - No ack on a timeout exit; the client request stays pending and is retried.
- INIT path: after INIT_WAIT completes, oinit_done=1. A timeout exit from INIT_WAIT returns to INIT_START instead of GAP.
- Refresh timer:
  - Runs only while oinit_done=1. Decrements every cycle.
  - At 0: reloads REFRESH_CYCLES-1 and sets ref_pending.
  - Expiry while ref_pending=1: set oref_overrun; ref_pending stays 1.
  - ref_pending clears on entry to REF_START.
- IDLE priority, evaluated each cycle:
  1. ref_pending → REF_START.
  2. Both iwr_req and ird_req high → serve the one not equal to last_served.
  3. iwr_req alone → WR_START.
  4. ird_req alone → RD_START.
  5. Otherwise stay in IDLE.
- last_served updates on entry to WR_START or RD_START.
- Refresh expiry coinciding with an IDLE→WR_START decision does not preempt it; the refresh is served at the next IDLE.
- Client latency: request high at edge N while IDLE → X_START visible after edge N. Minimum transaction is 4 cycles when fin arrives in the first WAIT cycle.

Decomposition:
- Shared package sdram_sched_pkg: state enum, served-type enum (READ/WRITE), default REFRESH_CYCLES and FIN_TIMEOUT constants.
- One natural sub-module, sdram_refresh_timer: down-counter, ref_pending, overrun flag, with enable and clear-pending inputs.
- FSM, arbitration and timeout logic stay in sdram_scheduler.

Test Plan:
- Reset then init:
  - Stimulus: release ctr_reset; init_fin pulsed 10 cycles after init_req.
  - Required: init_req high for 1 cycle after the first edge; init_enb high for 11 cycles then low for the GAP cycle; oinit_done=1 in the GAP cycle.
- Single write:
  - Stimulus: iwr_req=1 in IDLE; wr_fin arrives 6 cycles after wr_req.
  - Required: wr_enb high for 7 cycles; owr_ack pulses exactly once in GAP; no other enb ever high.
- Contention:
  - Stimulus: iwr_req=ird_req=1 held for 4 transactions.
  - Required: service order RD, WR, RD, WR; last_served resets to READ, so WRITE goes first only if the first grant after reset is a read; check the order matches the alternation rule.
- Refresh priority (REFRESH_CYCLES=20):
  - Stimulus: refresh expiry occurs during WR_WAIT.
  - Required: after GAP, REF_START is chosen over a still-pending ird_req; ref_enb pulse follows.
- Overrun:
  - Stimulus: REFRESH_CYCLES=20 with wr_fin held off; FIN_TIMEOUT=255.
  - Required: oref_overrun=1 at the second expiry.
  - Required: otimeout=1 after 255 WAIT cycles; no owr_ack; the write is retried.
- Async reset mid-RD_WAIT:
  - Stimulus: assert ctr_reset between edges.
  - Required: rd_enb and obusy drop within the same cycle; state returns to INIT_START; sticky flags clear.
